prio_axis_mux: RTL and testbench

Packet-granular AXI-Stream multiplexer directly downstream of the priority scheduler. Takes the scheduler's `sel_out`/`en_out` and the per-FIFO AXI-Stream buses. Locks onto the selected FIFO for one whole packet and forwards it to a single master stream through a registered skid stage. Reports packet completion per FIFO back to the scheduler's `fifo_tlast` input.

---
 rtl/prio_sched_pkg.sv | 18 +
 rtl/axis_skid_reg.sv | 66 ++++++
 rtl/prio_axis_mux.sv | 168 ++++++++++++++++
 tb/tb_prio_axis_mux.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_sched_pkg.sv
// Shared types and constants for the priority scheduler / AXI-Stream mux slice.
package prio_sched_pkg;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StXfer = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_NUM_FIFO   = 3;
    localparam int unsigned DEFAULT_DATA_WIDTH = 64;
    localparam int unsigned STAT_CNT_WIDTH     = 32;

    // A single-FIFO build still needs a 1-bit select port.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXI-Stream register slice (data, keep, last); head entry drives the master side.
module axis_skid_reg #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic [KEEP_WIDTH-1:0] i_s_keep,
    input  logic                  i_s_last,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic [KEEP_WIDTH-1:0] o_m_keep,
    output logic                  o_m_last
);

    localparam int unsigned PW = DATA_WIDTH + KEEP_WIDTH + 1;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [1:0]    r_cnt;
    logic [PW-1:0] w_in;
    logic          w_push;
    logic          w_pop;

    assign w_in      = {i_s_data, i_s_keep, i_s_last};
    assign o_s_ready = (r_cnt != 2'd2);
    assign o_m_valid = (r_cnt != 2'd0);
    assign w_push    = i_s_valid & o_s_ready;
    assign w_pop     = o_m_valid & i_m_ready;

    assign {o_m_data, o_m_keep, o_m_last} = r_head;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= w_in;
                    end else begin
                        r_tail <= w_in;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                // Push and pop together only happens with one entry held (full blocks push).
                2'b11: begin
                    r_head <= w_in;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/prio_axis_mux.sv
// Packet-granular AXI-Stream mux locked to the scheduler's pick for one whole packet.
// Define PRIO_AXIS_MUX_STATS_EN to add per-FIFO packet and beat counters.
module prio_axis_mux
    import prio_sched_pkg::*;
#(
    parameter int unsigned NUM_FIFO   = DEFAULT_NUM_FIFO,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned SEL_WIDTH = sel_width(NUM_FIFO)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [SEL_WIDTH-1:0]               sel_in,
    input  logic                               en_in,
    input  logic [NUM_FIFO*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_FIFO*KEEP_WIDTH-1:0]     s_axis_tkeep,
    input  logic [NUM_FIFO-1:0]                s_axis_tvalid,
    input  logic [NUM_FIFO-1:0]                s_axis_tlast,
    output logic [NUM_FIFO-1:0]                s_axis_tready,
    output logic [DATA_WIDTH-1:0]              m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]              m_axis_tkeep,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,
    output logic [NUM_FIFO-1:0]                fifo_tlast_out,
`ifdef PRIO_AXIS_MUX_STATS_EN
    output logic [NUM_FIFO*STAT_CNT_WIDTH-1:0] stat_pkt_cnt,
    output logic [NUM_FIFO*STAT_CNT_WIDTH-1:0] stat_beat_cnt,
`endif
    output logic                               busy
);

    state_e                r_state;
    state_e                w_state_d;
    logic [SEL_WIDTH-1:0]  r_cur_sel;
    logic [SEL_WIDTH-1:0]  w_cur_sel_d;
    logic [NUM_FIFO-1:0]   r_fifo_tlast;
    logic [NUM_FIFO-1:0]   w_fifo_tlast_d;

    logic                  w_req_valid;
    logic                  w_cur_valid;
    logic                  w_cur_last;
    logic [DATA_WIDTH-1:0] w_cur_data;
    logic [KEEP_WIDTH-1:0] w_cur_keep;
    logic                  w_skid_valid;
    logic                  w_skid_ready;
    logic                  w_accept;

    // An out-of-range sel_in matches no index, so it can never raise w_req_valid.
    always_comb begin
        w_req_valid = 1'b0;
        w_cur_valid = 1'b0;
        w_cur_last  = 1'b0;
        w_cur_data  = '0;
        w_cur_keep  = '0;
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            if (sel_in == SEL_WIDTH'(i)) begin
                w_req_valid = s_axis_tvalid[i];
            end
            if (r_cur_sel == SEL_WIDTH'(i)) begin
                w_cur_valid = s_axis_tvalid[i];
                w_cur_last  = s_axis_tlast[i];
                w_cur_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_cur_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    assign w_skid_valid = (r_state == StXfer) & w_cur_valid;
    assign w_accept     = w_skid_valid & w_skid_ready;

    always_comb begin
        w_state_d      = r_state;
        w_cur_sel_d    = r_cur_sel;
        w_fifo_tlast_d = '0;
        unique case (r_state)
            StIdle: begin
                // Hold off while the completion pulse is out so the scheduler can re-arbitrate.
                if (en_in && w_req_valid && (r_fifo_tlast == '0)) begin
                    w_state_d   = StXfer;
                    w_cur_sel_d = sel_in;
                end
            end
            StXfer: begin
                if (w_accept && w_cur_last) begin
                    w_state_d = StIdle;
                    for (int unsigned i = 0; i < NUM_FIFO; i++) begin
                        w_fifo_tlast_d[i] = (r_cur_sel == SEL_WIDTH'(i));
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            s_axis_tready[i] = (r_state == StXfer) && (r_cur_sel == SEL_WIDTH'(i)) && w_skid_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_cur_sel    <= '0;
            r_fifo_tlast <= '0;
        end else begin
            r_state      <= w_state_d;
            r_cur_sel    <= w_cur_sel_d;
            r_fifo_tlast <= w_fifo_tlast_d;
        end
    end

    assign fifo_tlast_out = r_fifo_tlast;
    assign busy           = (r_state == StXfer);

    axis_skid_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_s_valid (w_skid_valid),
        .o_s_ready (w_skid_ready),
        .i_s_data  (w_cur_data),
        .i_s_keep  (w_cur_keep),
        .i_s_last  (w_cur_last),
        .o_m_valid (m_axis_tvalid),
        .i_m_ready (m_axis_tready),
        .o_m_data  (m_axis_tdata),
        .o_m_keep  (m_axis_tkeep),
        .o_m_last  (m_axis_tlast)
    );

`ifdef PRIO_AXIS_MUX_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] r_pkt_cnt  [NUM_FIFO];
    logic [STAT_CNT_WIDTH-1:0] r_beat_cnt [NUM_FIFO];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            if (!rst) begin
                r_pkt_cnt[i]  <= '0;
                r_beat_cnt[i] <= '0;
            end else begin
                if (r_fifo_tlast[i]) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + STAT_CNT_WIDTH'(1);
                end
                if (w_accept && (r_cur_sel == SEL_WIDTH'(i))) begin
                    r_beat_cnt[i] <= r_beat_cnt[i] + STAT_CNT_WIDTH'(1);
                end
            end
        end
    end

    always_comb begin
        stat_pkt_cnt  = '0;
        stat_beat_cnt = '0;
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            stat_pkt_cnt[i*STAT_CNT_WIDTH +: STAT_CNT_WIDTH]  = r_pkt_cnt[i];
            stat_beat_cnt[i*STAT_CNT_WIDTH +: STAT_CNT_WIDTH] = r_beat_cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_prio_axis_mux.sv
// Directed bench for prio_axis_mux: drivers push expected beats, a monitor pops and compares.
module tb_prio_axis_mux;
    import prio_sched_pkg::*;

    localparam int NF = 3;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [SW-1:0]    sel_in = '0;
    logic             en_in = 1'b0;
    logic [NF*DW-1:0] s_axis_tdata;
    logic [NF*KW-1:0] s_axis_tkeep;
    logic [NF-1:0]    s_axis_tvalid;
    logic [NF-1:0]    s_axis_tlast;
    logic [NF-1:0]    s_axis_tready;
    logic [DW-1:0]    m_axis_tdata;
    logic [KW-1:0]    m_axis_tkeep;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready = 1'b1;
    logic [NF-1:0]    fifo_tlast_out;
    logic             busy;
`ifdef PRIO_AXIS_MUX_STATS_EN
    logic [NF*32-1:0] stat_pkt_cnt;
    logic [NF*32-1:0] stat_beat_cnt;
`endif

    logic [DW-1:0] b_data  [NF];
    logic [KW-1:0] b_keep  [NF];
    logic          b_valid [NF];
    logic          b_last  [NF];

    always_comb begin
        for (int i = 0; i < NF; i++) begin
            s_axis_tdata[i*DW +: DW] = b_data[i];
            s_axis_tkeep[i*KW +: KW] = b_keep[i];
            s_axis_tvalid[i]         = b_valid[i];
            s_axis_tlast[i]          = b_last[i];
        end
    end

    prio_axis_mux dut (
        .clk            (clk),
        .rst            (rst),
        .sel_in         (sel_in),
        .en_in          (en_in),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .fifo_tlast_out (fifo_tlast_out),
`ifdef PRIO_AXIS_MUX_STATS_EN
        .stat_pkt_cnt   (stat_pkt_cnt),
        .stat_beat_cnt  (stat_beat_cnt),
`endif
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [72:0] exp_q[$];
    int          acc_cyc_q[$];
    bit          lat_en = 1'b0;
    bit          abort  = 1'b0;
    int          acc_cnt   [NF];
    int          pulse_cnt [NF];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Output monitor: scoreboard pop, latency and hold-stability.
    logic        hold_prev = 1'b0;
    logic [72:0] held;
    always @(negedge clk) begin
        logic [72:0] e;
        if (!rst) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev && m_axis_tvalid) begin
                check("hold_stable", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(held));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h, want no beat", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(e));
                    if (lat_en && acc_cyc_q.size() > 0) begin
                        check("latency", 128'(cyc - acc_cyc_q.pop_front()), 128'(1));
                    end
                end
            end
            hold_prev = m_axis_tvalid && !m_axis_tready;
            held      = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end
    end

    // Completion pulse monitor.
    logic [NF-1:0] prev_ftl = '0;
    always @(negedge clk) begin
        if (fifo_tlast_out != '0) begin
            check("pulse_onehot", 128'($onehot(fifo_tlast_out)), 128'(1));
            check("pulse_one_cycle", 128'(fifo_tlast_out & prev_ftl), 128'(0));
        end
        for (int i = 0; i < NF; i++) pulse_cnt[i] += int'(fifo_tlast_out[i]);
        prev_ftl = fifo_tlast_out;
    end

    task automatic send_pkt(input int f, input int n, input logic [DW-1:0] base);
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        bit            got;
        for (int b = 0; b < n; b++) begin
            d = base + DW'(b);
            k = (b == n - 1) ? 8'h0F : 8'hFF;
            l = (b == n - 1);
            b_data[f]  = d;
            b_keep[f]  = k;
            b_last[f]  = l;
            b_valid[f] = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (abort) break;
                if (s_axis_tready[f]) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                if (!abort) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout fifo%0d beat%0d: got no ready, want ready", f, b);
                end
                b_valid[f] = 1'b0;
                b_last[f]  = 1'b0;
                return;
            end
            exp_q.push_back({d, k, l});
            acc_cnt[f]++;
            if (lat_en) acc_cyc_q.push_back(cyc);
            @(posedge clk);
            #1;
        end
        b_valid[f] = 1'b0;
        b_last[f]  = 1'b0;
    endtask

    task automatic wait_acc(input int f, input int n);
        for (int t = 0; t < 200; t++) begin
            if (acc_cnt[f] >= n) return;
            @(negedge clk);
        end
        total++;
        bad++;
        $display("FAIL wait_acc fifo%0d: got %0d beats, want %0d", f, acc_cnt[f], n);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mvalid"}, 128'(m_axis_tvalid), 128'(0));
        check({tag, "_sready"}, 128'(s_axis_tready), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit done0;
        int badr;
        for (int i = 0; i < NF; i++) begin
            b_data[i]  = '0;
            b_keep[i]  = '0;
            b_valid[i] = 1'b0;
            b_last[i]  = 1'b0;
        end

        // Reset, then idle with nothing valid.
        repeat (3) begin
            @(negedge clk);
            check_idle("rst");
            check("rst_mdata", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(0));
            check("rst_ftl", 128'(fifo_tlast_out), 128'(0));
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_idle("idle");
        end

        // Single 4-beat packet on FIFO 2.
        lat_en = 1'b1;
        sel_in = 2'd2;
        en_in  = 1'b1;
        send_pkt(2, 4, 64'hA0);
        @(negedge clk);
        check("t2_pulse", 128'(fifo_tlast_out), 128'(3'b100));
        check("t2_busy_end", 128'(busy), 128'(0));
        @(negedge clk);
        check("t2_pulse_gone", 128'(fifo_tlast_out), 128'(0));
        lat_en = 1'b0;
        check("t2_pulse_cnt", 128'(pulse_cnt[2]), 128'(1));

        // FIFO 0 packet of 5, select moves to FIFO 1 after beat 2.
        sel_in = 2'd0;
        done0  = 1'b0;
        badr   = 0;
        fork
            begin
                send_pkt(0, 5, 64'hB0);
                done0 = 1'b1;
            end
            begin
                wait_acc(0, 2);
                sel_in = 2'd1;
                send_pkt(1, 1, 64'hC0);
            end
            begin
                for (int t = 0; t < 300 && !done0; t++) begin
                    @(negedge clk);
                    if (!done0 && s_axis_tready[1]) badr++;
                end
            end
        join
        repeat (3) @(negedge clk);
        check("t3_ready1_held_off", 128'(badr), 128'(0));
        check("t3_pulse0", 128'(pulse_cnt[0]), 128'(1));
        check("t3_pulse1", 128'(pulse_cnt[1]), 128'(1));

        // Backpressure: 8-beat packet on FIFO 1 with the master stalled.
        m_axis_tready = 1'b0;
        acc_cnt[1]    = 0;
        fork
            send_pkt(1, 8, 64'hD0);
            begin
                repeat (10) @(negedge clk);
                check("t4_absorbed", 128'(acc_cnt[1]), 128'(2));
                check("t4_sready", 128'(s_axis_tready), 128'(0));
                check("t4_mvalid", 128'(m_axis_tvalid), 128'(1));
                check("t4_head", 128'({m_axis_tdata, m_axis_tlast}), 128'({64'hD0, 1'b0}));
                @(posedge clk);
                #1 m_axis_tready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        check("t4_pulse1", 128'(pulse_cnt[1]), 128'(2));
        check("t4_drained", 128'(exp_q.size()), 128'(0));

        // Out-of-range select, then en_in low: nothing may start.
        for (int i = 0; i < NF; i++) begin
            b_valid[i] = 1'b1;
            b_last[i]  = 1'b1;
        end
        sel_in = 2'd3;
        repeat (5) begin
            @(negedge clk);
            check_idle("oor");
        end
        en_in  = 1'b0;
        sel_in = 2'd0;
        repeat (3) begin
            @(negedge clk);
            check_idle("en_low");
        end
        for (int i = 0; i < NF; i++) begin
            b_valid[i] = 1'b0;
            b_last[i]  = 1'b0;
        end
        en_in = 1'b1;
        repeat (2) @(negedge clk);

        // Reset mid-packet with two beats parked in the skid stage.
        m_axis_tready = 1'b0;
        acc_cnt[0]    = 0;
        p0            = pulse_cnt[0];
        fork
            send_pkt(0, 6, 64'hE0);
            begin
                wait_acc(0, 2);
                @(posedge clk);
                #1;
                rst   = 1'b0;
                abort = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_idle("t6");
                check("t6_mdata", 128'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 128'(0));
`ifdef PRIO_AXIS_MUX_STATS_EN
                check("t6_stat_pkt", 128'(stat_pkt_cnt), 128'(0));
                check("t6_stat_beat", 128'(stat_beat_cnt), 128'(0));
`endif
                exp_q.delete();
                @(posedge clk);
                #1 rst = 1'b1;
            end
        join
        abort         = 1'b0;
        m_axis_tready = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_no_pulse", 128'(pulse_cnt[0]), 128'(p0));
        check_idle("t6_after");
        check("end_queue_empty", 128'(exp_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
